// File: rtl/conv_ci_pkg.sv
// rtl/conv_ci_pkg.sv - shared types and helpers for the convolution CI initiator
//
// Purpose: FSM state encoding, default CI width, sequence-number width and
//          the zero-extension helper used to build CI operands.
// Ports:   none (package)

package conv_ci_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } ci_state_t;

  localparam int CI_W_DEF = 32;
  localparam int SEQ_W    = 16;

  // Zero-extend a sequence number to a full-width CI operand.
  function automatic logic [CI_W_DEF-1:0] zext_to_ci(input logic [SEQ_W-1:0] v);
    return {{(CI_W_DEF-SEQ_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/conv_ci_initiator.sv
// rtl/conv_ci_initiator.sv - stream-to-custom-instruction initiator for the convolution CI
//
// Purpose: accepts one sample at a time from a ready/valid stream, runs one
//          multi-cycle CI transaction per sample (dataa = sample, datab = seq),
//          and forwards result[DATA_W-1:0] on a ready/valid output stream.
//          A transaction that sees no done within TIMEOUT enabled cycles is
//          aborted with a zero result and a sticky error flag.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   in_data/valid/ready  input sample stream
//   out_data/valid/ready output result stream
//   ci_clk_en, ci_start  CI enable (whole transaction) and one-cycle start
//   ci_dataa, ci_datab   CI operands {0, sample} and {0, seq}
//   ci_result, ci_done   CI response
//   err_timeout, err_clr sticky timeout flag and its synchronous clear

module conv_ci_initiator
  import conv_ci_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CI_W    = CI_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic [CI_W-1:0]   ci_dataa,
  output logic [CI_W-1:0]   ci_datab,
  input  logic [CI_W-1:0]   ci_result,
  input  logic              ci_done,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  ci_state_t          r_state;
  ci_state_t          w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_ci_clk_en;
  logic               r_ci_start;
  logic [CI_W-1:0]    r_ci_dataa;
  logic [CI_W-1:0]    r_ci_datab;
  logic               r_err_timeout;
  logic [SEQ_W-1:0]   r_seq;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_done_hit;
  logic               w_timeout;

  // Next-state logic. in_ready is registered, so the handshake is qualified
  // with r_in_ready (it stays low for the first cycle after reset release).
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_hit  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (ci_done) begin
          w_done_hit  = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // done on the final allowed cycle still counts as a completion
        if (ci_done) begin
          w_done_hit  = 1'b1;
          w_state_nxt = HOLD;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus registered outputs decoded from the next state, so
  // every output changes exactly on the edge that enters the new state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_ci_clk_en   <= 1'b0;
      r_ci_start    <= 1'b0;
      r_ci_dataa    <= '0;
      r_ci_datab    <= '0;
      r_err_timeout <= 1'b0;
      r_seq         <= '0;
      r_cnt         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_ci_start  <= (w_state_nxt == ISSUE);
      r_ci_clk_en <= (w_state_nxt == ISSUE) || (w_state_nxt == WAIT);
      r_out_valid <= (w_state_nxt == HOLD);

      if (w_accept) begin
        r_ci_dataa <= CI_W'(in_data);
        r_ci_datab <= CI_W'(zext_to_ci(r_seq));
      end

      // Zero during ISSUE, 1 on the first WAIT cycle: ISSUE plus WAIT cycles
      // together give TIMEOUT enabled cycles before the abort.
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == ISSUE || r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_done_hit) begin
        r_out_data <= ci_result[DATA_W-1:0];
      end else if (w_timeout) begin
        r_out_data <= '0;
      end

      // a timeout in the same cycle as err_clr leaves the flag set
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end else if (err_clr) begin
        r_err_timeout <= 1'b0;
      end

      if (r_state == HOLD && out_ready) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
    end
  end

  generate
    if (CI_W > DATA_W) begin : g_result_hi
      logic w_unused_result_hi;
      assign w_unused_result_hi = ^ci_result[CI_W-1:DATA_W];
    end
  endgenerate

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign ci_clk_en   = r_ci_clk_en;
  assign ci_start    = r_ci_start;
  assign ci_dataa    = r_ci_dataa;
  assign ci_datab    = r_ci_datab;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_conv_ci_initiator.sv
// tb/tb_conv_ci_initiator.sv - self-checking bench for conv_ci_initiator

module tb_conv_ci_initiator;

  localparam int DATA_W  = 16;
  localparam int CI_W    = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              ci_clk_en;
  logic              ci_start;
  logic [CI_W-1:0]   ci_dataa;
  logic [CI_W-1:0]   ci_datab;
  logic [CI_W-1:0]   ci_result = '0;
  logic              ci_done = 1'b0;
  logic              err_timeout;
  logic              err_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_g    = 0;

  // reference model state
  logic [15:0] seq_m = 16'h0;
  logic        err_m = 1'b0;

  conv_ci_initiator #(.DATA_W(DATA_W), .CI_W(CI_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ci_clk_en(ci_clk_en), .ci_start(ci_start),
    .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_result(ci_result), .ci_done(ci_done),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete transaction. d = cycles from start to done (d >= TIMEOUT
  // means the responder stays silent). hold = cycles out_ready is held low.
  // clr_last pulses err_clr on the final enabled cycle of the transaction.
  task automatic run_txn(input logic [15:0] smp, input int d, input logic [31:0] res,
                         input int hold, input bit clr_last, output int ov_cyc);
    int          cyc;
    int          en_cnt;
    int          bad;
    int          lat_exp;
    bit          to;
    logic [15:0] out_exp;
    to      = (d > TIMEOUT - 1);
    lat_exp = to ? TIMEOUT + 1 : 2 + d;
    bad     = 0;
    cyc     = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_data  = smp;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    check_eq("ci_start_issue", 32'(ci_start), 32'd1);
    check_eq("ci_dataa", ci_dataa, {16'h0, smp});
    check_eq("ci_datab", ci_datab, {16'h0, seq_m});
    cyc    = 1;
    en_cnt = 0;
    while (!out_valid && cyc <= TIMEOUT + 4) begin
      if (ci_clk_en) en_cnt++;
      if (in_ready || ci_start !== (cyc == 1) || ci_dataa !== {16'h0, smp}) bad++;
      ci_done   = !to && (cyc == d + 1);
      ci_result = ci_done ? res : $urandom;
      err_clr   = clr_last && (cyc == lat_exp - 1);
      tick();
      cyc++;
    end
    ci_done = 1'b0;
    err_clr = 1'b0;
    ov_cyc  = cyc_g;
    out_exp = to ? 16'h0 : res[15:0];
    if (to) err_m = 1'b1;
    else if (clr_last) err_m = 1'b0;
    check_eq("latency", 32'(cyc), 32'(lat_exp));
    check_eq("clk_en_cycles", 32'(en_cnt), 32'(lat_exp - 1));
    check_eq("clk_en_hold", 32'(ci_clk_en), 32'd0);
    check_eq("out_data", 32'(out_data), 32'(out_exp));
    check_eq("err_timeout", 32'(err_timeout), 32'(err_m));
    check_eq("txn_stable", 32'(bad), 32'd0);
    for (int i = 0; i < hold; i++) begin
      ci_done = 1'($urandom);
      if (!out_valid || in_ready || ci_start || ci_clk_en || out_data !== out_exp) bad++;
      tick();
    end
    ci_done = 1'b0;
    if (hold > 0) check_eq("hold_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("out_valid_drop", 32'(out_valid), 32'd0);
    seq_m = seq_m + 16'd1;
  endtask

  initial begin
    int ov [4];
    int ovx;
    int d;

    // 1: reset
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_clk_en", 32'(ci_clk_en), 32'd0);
    check_eq("rst_start", 32'(ci_start), 32'd0);
    check_eq("rst_dataa", ci_dataa, 32'd0);
    check_eq("rst_datab", ci_datab, 32'd0);
    check_eq("rst_err", 32'(err_timeout), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("in_ready_at_release", 32'(in_ready), 32'd0);
    tick();
    check_eq("in_ready_after_release", 32'(in_ready), 32'd1);

    // 2: done three cycles after start
    run_txn(16'h1234, 3, 32'h0000_ABCD, 0, 1'b0, ovx);

    // 3: zero-latency responder, back to back
    for (int i = 0; i < 4; i++) run_txn(16'($urandom), 0, $urandom, 0, 1'b0, ov[i]);
    for (int i = 1; i < 4; i++) check_eq("b2b_period", 32'(ov[i] - ov[i-1]), 32'd3);

    // 4: silent responder, then clear; then clear racing a second timeout
    run_txn(16'h5555, TIMEOUT + 5, 32'h0, 0, 1'b0, ovx);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m   = 1'b0;
    check_eq("err_clr", 32'(err_timeout), 32'd0);
    run_txn(16'h6666, TIMEOUT + 5, 32'h0, 0, 1'b1, ovx);
    run_txn(16'h7777, TIMEOUT - 1, 32'hFFFF_0042, 0, 1'b1, ovx);

    // 5: long backpressure
    run_txn(16'hBEEF, 2, 32'h1234_C0DE, 10, 1'b0, ovx);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = $urandom_range(0, TIMEOUT + 2);
      run_txn(16'($urandom), d, $urandom, $urandom_range(0, 3), 1'($urandom), ovx);
    end

    // 6: sequence wrap; jump the sequence counter close to its wrap point
    dut.r_seq <= 16'hFFFD;
    seq_m = 16'hFFFD;
    tick();
    for (int i = 0; i < 4; i++) run_txn(16'($urandom), $urandom_range(0, 2), $urandom, 0, 1'b0, ovx);
    check_eq("seq_wrapped", 32'(seq_m), 32'd1);

    // reset in the middle of WAIT
    in_data  = 16'h4321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check_eq("mid_wait_clk_en", 32'(ci_clk_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_clk_en", 32'(ci_clk_en), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("mid_rst_datab", ci_datab, 32'd0);
    check_eq("mid_rst_dataa", ci_dataa, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seq_m = 16'h0;
    err_m = 1'b0;
    tick();
    check_eq("in_ready_after_rerelease", 32'(in_ready), 32'd1);
    run_txn(16'hA5A5, 1, 32'h0000_5A5A, 0, 1'b0, ovx);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
